// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, lock acquisition with retries
// and stable-lock qualification before releasing the system reset.
`timescale 1ns/1ps
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int CNT_W          = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       clear_stats,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST =
        CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST =
        CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             sync_q;
    logic             locked_s;
    logic [2:0]       retry_inc;

    assign retry_inc = retry_count + 3'd1;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= locked_in;
            locked_s <= sync_q;
        end
    end

    // {pll_rst, sys_rst, ready, fault} seen while in a state
    function automatic logic [3:0] decode(input state_t s);
        logic [3:0] o;
        o = 4'b1100;
        case (s)
            ST_PLL_RESET: o = 4'b1100;
            ST_WAIT_LOCK: o = 4'b0100;
            ST_STABILIZE: o = 4'b0100;
            ST_RUN:       o = 4'b0010;
            ST_FAULT:     o = 4'b1101;
            default:      o = 4'b1100;
        endcase
        return o;
    endfunction

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state           <= ST_PLL_RESET;
            timer           <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
            {pll_rst, sys_rst, ready, fault} <= decode(ST_PLL_RESET);
        end else begin
            timer <= timer + CNT_ONE;
            unique case (state)
                ST_PLL_RESET: begin
                    if (timer == RST_LAST) begin
                        state <= ST_WAIT_LOCK;
                        timer <= '0;
                        {pll_rst, sys_rst, ready, fault} <=
                            decode(ST_WAIT_LOCK);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= ST_STABILIZE;
                        timer <= '0;
                        {pll_rst, sys_rst, ready, fault} <=
                            decode(ST_STABILIZE);
                    end else if (timer == TIMEOUT_LAST) begin
                        retry_count <= retry_inc;
                        timer       <= '0;
                        if (retry_inc == RETRY_LIMIT) begin
                            state <= ST_FAULT;
                            {pll_rst, sys_rst, ready, fault} <=
                                decode(ST_FAULT);
                        end else begin
                            state <= ST_PLL_RESET;
                            {pll_rst, sys_rst, ready, fault} <=
                                decode(ST_PLL_RESET);
                        end
                    end
                end
                ST_STABILIZE: begin
                    // a drop restarts the timeout but is not a retry
                    if (!locked_s) begin
                        state <= ST_WAIT_LOCK;
                        timer <= '0;
                        {pll_rst, sys_rst, ready, fault} <=
                            decode(ST_WAIT_LOCK);
                    end else if (timer == STABLE_LAST) begin
                        state <= ST_RUN;
                        timer <= '0;
                        {pll_rst, sys_rst, ready, fault} <=
                            decode(ST_RUN);
                    end
                end
                ST_RUN: begin
                    timer <= '0;
                    if (!locked_s) begin
                        state       <= ST_PLL_RESET;
                        retry_count <= '0;
                        {pll_rst, sys_rst, ready, fault} <=
                            decode(ST_PLL_RESET);
                        if (lock_loss_count != 8'hFF)
                            lock_loss_count <= lock_loss_count + 8'd1;
                    end
                end
                ST_FAULT: begin
                    timer <= '0;
                end
                default: begin
                    state <= ST_PLL_RESET;
                    timer <= '0;
                    {pll_rst, sys_rst, ready, fault} <=
                        decode(ST_PLL_RESET);
                end
            endcase
            if (clear_stats)
                lock_loss_count <= '0;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios and random lock
// activity checked against a phase-level reference model.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 100;
    localparam int P_STAB = 8;
    localparam int P_MAX  = 3;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       locked_in = 1'b0;
    logic       clear_stats = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [2:0] retry_count;
    logic [7:0] lock_loss_count;

    int n_chk = 0;
    int n_fail = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .STABLE_CYCLES (P_STAB),
        .MAX_RETRIES   (P_MAX),
        .CNT_W         (16)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .locked_in      (locked_in),
        .clear_stats    (clear_stats),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    // reference model: phase, edges spent in phase, counters, 2-edge delay
    typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAULT} mph_t;
    mph_t m_ph = M_RST;
    int   m_t = 0;
    int   m_retry = 0;
    int   m_loss = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    task automatic model_reset();
        m_ph = M_RST;
        m_t = 0;
        m_retry = 0;
        m_loss = 0;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
    endtask

    task automatic model_step(input logic lk, input logic clr);
        logic ls;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        case (m_ph)
            M_RST: begin
                m_t++;
                if (m_t == P_RST) begin m_ph = M_WAIT; m_t = 0; end
            end
            M_WAIT: begin
                if (ls) begin
                    m_ph = M_STAB; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == P_TO) begin
                        m_retry++;
                        m_ph = (m_retry == P_MAX) ? M_FAULT : M_RST;
                        m_t = 0;
                    end
                end
            end
            M_STAB: begin
                if (!ls) begin
                    m_ph = M_WAIT; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == P_STAB) begin m_ph = M_RUN; m_t = 0; end
                end
            end
            M_RUN: begin
                if (!ls) begin
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                    m_retry = 0;
                    m_ph = M_RST;
                    m_t = 0;
                end
            end
            default: ;
        endcase
        if (clr) m_loss = 0;
    endtask

    function automatic logic [3:0] m_flags();
        logic [3:0] f;
        f[3] = (m_ph == M_RST) || (m_ph == M_FAULT);
        f[2] = (m_ph != M_RUN);
        f[1] = (m_ph == M_RUN);
        f[0] = (m_ph == M_FAULT);
        return f;
    endfunction

    task automatic tick(input logic lk, input logic clr);
        locked_in = lk;
        clear_stats = clr;
        @(posedge refclk);
        model_step(lk, clr);
        @(negedge refclk);
        clear_stats = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        locked_in = 1'b0;
        clear_stats = 1'b0;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_to(input mph_t ph, input logic lk, input int bound);
        int k;
        k = 0;
        while (m_ph != ph && k < bound) begin
            tick(lk, 1'b0);
            k++;
        end
        if (m_ph != ph) begin
            n_chk++; n_fail++;
            $display("FAIL run_to bound: phase %0d not reached in %0d edges",
                     ph, bound);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge refclk);
        n_chk++;
        if ({pll_rst, sys_rst, ready, fault} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 1100",
                     {pll_rst, sys_rst, ready, fault});
        end
        n_chk++;
        if (retry_count !== 3'd0 || lock_loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counts got retry=%0d loss=%0d want 0 0",
                     retry_count, lock_loss_count);
        end
    endtask

    task automatic test_lock_sequence();
        int fall;
        int first;
        do_reset();
        fall = -1;
        for (int n = 1; n <= 20 && fall < 0; n++) begin
            tick(1'b0, 1'b0);
            if (pll_rst === 1'b0) fall = n;
        end
        n_chk++;
        if (fall != 4) begin
            n_fail++;
            $display("FAIL pll_rst_width got %0d want 4", fall);
        end
        repeat (10) tick(1'b0, 1'b0);
        first = -1;
        for (int e = 0; e < 30 && first < 0; e++) begin
            tick(1'b1, 1'b0);
            if (ready === 1'b1) first = e;
        end
        n_chk++;
        if (first != 2 + P_STAB) begin
            n_fail++;
            $display("FAIL lock_to_ready got %0d edges want %0d",
                     first, 2 + P_STAB);
        end
        n_chk++;
        if (sys_rst !== 1'b0 || retry_count !== 3'd0) begin
            n_fail++;
            $display("FAIL run_outputs got sys_rst=%b retry=%0d want 0 0",
                     sys_rst, retry_count);
        end
    endtask

    task automatic test_timeout_fault();
        logic bad;
        do_reset();
        for (int n = 1; n <= 312; n++) begin
            tick(1'b0, 1'b0);
            if (n == 103 || n == 108 || n == 207) begin
                n_chk++;
                if (pll_rst !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_low edge %0d got %b want 0",
                             n, pll_rst);
                end
            end
            if (n == 104 || n == 107 || n == 208) begin
                n_chk++;
                if (pll_rst !== 1'b1 || retry_count !== 3'(n / 104)) begin
                    n_fail++;
                    $display("FAIL timeout_pulse edge %0d got pll=%b retry=%0d want 1 %0d",
                             n, pll_rst, retry_count, n / 104);
                end
            end
            if (n == 311) begin
                n_chk++;
                if (fault !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fault_early got %b want 0", fault);
                end
            end
        end
        n_chk++;
        if ({pll_rst, sys_rst, ready, fault} !== 4'b1101 ||
            retry_count !== 3'd3) begin
            n_fail++;
            $display("FAIL fault_entry got flags=%b retry=%0d want 1101 3",
                     {pll_rst, sys_rst, ready, fault}, retry_count);
        end
        bad = 1'b0;
        repeat (40) begin
            tick(1'b1, 1'b0);
            if ({pll_rst, sys_rst, ready, fault} !== 4'b1101) bad = 1'b1;
        end
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_sticky got flags=%b want 1101",
                     {pll_rst, sys_rst, ready, fault});
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        run_to(M_RUN, 1'b1, 100);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_early got ready=%b want 1", ready);
        end
        tick(1'b0, 1'b0);
        n_chk++;
        if ({pll_rst, sys_rst, ready} !== 3'b110 ||
            lock_loss_count !== 8'd1) begin
            n_fail++;
            $display("FAIL loss_react got flags=%b loss=%0d want 110 1",
                     {pll_rst, sys_rst, ready}, lock_loss_count);
        end
        run_to(M_RUN, 1'b1, 50);
        n_chk++;
        if (ready !== 1'b1 || lock_loss_count !== 8'd1 ||
            retry_count !== 3'd0) begin
            n_fail++;
            $display("FAIL relock got ready=%b loss=%0d retry=%0d want 1 1 0",
                     ready, lock_loss_count, retry_count);
        end
    endtask

    task automatic test_stabilize_glitch();
        int  first;
        logic bad;
        do_reset();
        repeat (P_RST + P_TO) tick(1'b0, 1'b0);
        run_to(M_STAB, 1'b1, 50);
        repeat (3) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        first = -1;
        bad = 1'b0;
        for (int e = 2; e < 30 && first < 0; e++) begin
            tick(1'b1, 1'b0);
            if (pll_rst !== 1'b0 || retry_count !== 3'd1) bad = 1'b1;
            if (ready === 1'b1) first = e;
        end
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_retry got pll=%b retry=%0d want 0 1",
                     pll_rst, retry_count);
        end
        n_chk++;
        if (first != 4 + P_STAB) begin
            n_fail++;
            $display("FAIL glitch_ready got %0d edges want %0d",
                     first, 4 + P_STAB);
        end
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            run_to(M_RUN, 1'b1, 60);
            tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
            tick(1'b1, 1'b0);
            want = (i < 255) ? i : 255;
            n_chk++;
            if (lock_loss_count !== 8'(want)) begin
                n_fail++;
                $display("FAIL loss_count iter %0d got %0d want %0d",
                         i, lock_loss_count, want);
            end
        end
        run_to(M_RUN, 1'b1, 60);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        n_chk++;
        if (lock_loss_count !== 8'd0 || pll_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_wins got loss=%0d pll=%b want 0 1",
                     lock_loss_count, pll_rst);
        end
        run_to(M_RUN, 1'b1, 60);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        run_to(M_RUN, 1'b1, 60);
        tick(1'b1, 1'b1);
        n_chk++;
        if (lock_loss_count !== 8'd0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_in_run got loss=%0d ready=%b want 0 1",
                     lock_loss_count, ready);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (P_RST + P_TO) tick(1'b0, 1'b0);
        run_to(M_STAB, 1'b1, 50);
        tick(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({pll_rst, sys_rst, ready, fault} !== 4'b1100 ||
            retry_count !== 3'd0) begin
            n_fail++;
            $display("FAIL async_stab got flags=%b retry=%0d want 1100 0",
                     {pll_rst, sys_rst, ready, fault}, retry_count);
        end
        @(negedge refclk);
        rst = 1'b0;
        model_reset();
        run_to(M_RUN, 1'b1, 60);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        run_to(M_RUN, 1'b1, 60);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({pll_rst, sys_rst, ready, fault} !== 4'b1100 ||
            lock_loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_run got flags=%b loss=%0d want 1100 0",
                     {pll_rst, sys_rst, ready, fault}, lock_loss_count);
        end
        @(negedge refclk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic lk;
        logic clr;
        int   len;
        int   e;
        do_reset();
        lk = 1'b0;
        e = 0;
        while (e < 4000) begin
            lk = ~lk;
            if (lk)
                len = int'($urandom_range(40, 1));
            else if ($urandom_range(3, 0) == 0)
                len = int'($urandom_range(130, 90));
            else
                len = int'($urandom_range(12, 1));
            for (int i = 0; i < len; i++) begin
                clr = ($urandom_range(63, 0) == 0);
                tick(lk, clr);
                e++;
                n_chk++;
                if ({pll_rst, sys_rst, ready, fault} !== m_flags() ||
                    retry_count !== 3'(m_retry) ||
                    lock_loss_count !== 8'(m_loss)) begin
                    n_fail++;
                    $display("FAIL random edge %0d got f=%b r=%0d l=%0d want f=%b r=%0d l=%0d",
                             e, {pll_rst, sys_rst, ready, fault},
                             retry_count, lock_loss_count,
                             m_flags(), m_retry, m_loss);
                end
                if (m_ph == M_FAULT && $urandom_range(7, 0) == 0)
                    do_reset();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_sequence();
        test_timeout_fault();
        test_lock_loss();
        test_stabilize_glitch();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
